// File: rtl/r_type_pkg.sv
// rtl/r_type_pkg.sv - shared constants, field positions and state type for the R-type issue stage
package r_type_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_MUL = 6'b100110;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic funct_ok;
        case (funct)
            FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_AND, FUNCT_OR: funct_ok = 1'b1;
            default:                                              funct_ok = 1'b0;
        endcase
        return (op == OP_RTYPE) && funct_ok;
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 32x32 register file: two async reads, registered debug read, one write plus clear walk
module regfile_32x32
    import r_type_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              clr_we_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] dbg_rdata_q;

    assign rdata_a_o   = mem_q[raddr_a_i];
    assign rdata_b_o   = mem_q[raddr_b_i];
    assign dbg_rdata_o = dbg_rdata_q;

    // No reset on the array: contents are established by the clear walk.
    always_ff @(posedge clock) begin
        if (clr_we_i) begin
            mem_q[clr_addr_i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dbg_rdata_q <= '0;
        end else begin
            dbg_rdata_q <= mem_q[dbg_addr_i];
        end
    end

endmodule

// File: rtl/r_type_issue.sv
// rtl/r_type_issue.sv - R-type issue/writeback stage driving the ALU, with forwarding from the E stage
module r_type_issue
    import r_type_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int CLEAR_CYCLES = NREG
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              alu_valid,
    output logic [5:0]        alu_opcode,
    output logic [5:0]        alu_function,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              retire_valid,
    output logic [REG_AW-1:0] retire_rd,
    output logic [DATA_W-1:0] retire_data,
    output logic              illegal,
    input  logic              dbg_we,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              clr_walk;

    logic              e_valid_q, e_valid_d;
    logic [5:0]        e_op_q, e_op_d;
    logic [5:0]        e_funct_q, e_funct_d;
    logic [DATA_W-1:0] e_a_q, e_a_d;
    logic [DATA_W-1:0] e_b_q, e_b_d;
    logic [REG_AW-1:0] e_rd_q, e_rd_d;
    logic              illegal_q, illegal_d;

    logic              retire_valid_q, retire_valid_d;
    logic [REG_AW-1:0] retire_rd_q, retire_rd_d;
    logic [DATA_W-1:0] retire_data_q, retire_data_d;

    logic [5:0]        dec_op, dec_funct;
    logic [REG_AW-1:0] dec_rs, dec_rt, dec_rd;
    logic              accept, dec_legal;
    logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    logic              fwd_a, fwd_b;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              unused_shamt;

    assign dec_op       = instr[OP_MSB:OP_LSB];
    assign dec_rs       = instr[RS_MSB:RS_LSB];
    assign dec_rt       = instr[RT_MSB:RT_LSB];
    assign dec_rd       = instr[RD_MSB:RD_LSB];
    assign dec_funct    = instr[FUNCT_MSB:FUNCT_LSB];
    assign unused_shamt = ^instr[SHAMT_MSB:SHAMT_LSB];

    assign instr_ready = (state_q == RUN) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign dec_legal   = is_legal(dec_op, dec_funct);

    // ---------------- clear-walk FSM ----------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_walk  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_walk  = 1'b1;
                clr_cnt_d = clr_cnt_q + CW'(1);
                if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ---------------- operand read with forwarding ----------------
    always_comb begin
        fwd_a = e_valid_q && (e_rd_q != '0) && (dec_rs == e_rd_q);
        fwd_b = e_valid_q && (e_rd_q != '0) && (dec_rt == e_rd_q);
        if (dec_rs == '0)  opnd_a = '0;
        else if (fwd_a)    opnd_a = alu_result;
        else               opnd_a = rf_rdata_a;
        if (dec_rt == '0)  opnd_b = '0;
        else if (fwd_b)    opnd_b = alu_result;
        else               opnd_b = rf_rdata_b;
    end

    // ---------------- E stage and retire ----------------
    always_comb begin
        e_valid_d = 1'b0;
        e_op_d    = e_op_q;
        e_funct_d = e_funct_q;
        e_a_d     = e_a_q;
        e_b_d     = e_b_q;
        e_rd_d    = e_rd_q;
        illegal_d = 1'b0;
        if (accept) begin
            if (dec_legal) begin
                e_valid_d = 1'b1;
                e_op_d    = dec_op;
                e_funct_d = dec_funct;
                e_a_d     = opnd_a;
                e_b_d     = opnd_b;
                e_rd_d    = dec_rd;
            end else begin
                illegal_d = 1'b1;
            end
        end
        retire_valid_d = e_valid_q;
        retire_rd_d    = e_valid_q ? e_rd_q     : retire_rd_q;
        retire_data_d  = e_valid_q ? alu_result : retire_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_valid_q      <= 1'b0;
            e_op_q         <= '0;
            e_funct_q      <= '0;
            e_a_q          <= '0;
            e_b_q          <= '0;
            e_rd_q         <= '0;
            illegal_q      <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_rd_q    <= '0;
            retire_data_q  <= '0;
        end else begin
            e_valid_q      <= e_valid_d;
            e_op_q         <= e_op_d;
            e_funct_q      <= e_funct_d;
            e_a_q          <= e_a_d;
            e_b_q          <= e_b_d;
            e_rd_q         <= e_rd_d;
            illegal_q      <= illegal_d;
            retire_valid_q <= retire_valid_d;
            retire_rd_q    <= retire_rd_d;
            retire_data_q  <= retire_data_d;
        end
    end

    // Single write port: a real retire takes it ahead of a debug write.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            if (e_valid_q && (e_rd_q != '0)) begin
                rf_we    = 1'b1;
                rf_waddr = e_rd_q;
                rf_wdata = alu_result;
            end else if (dbg_we && (state_q == RUN)) begin
                rf_we    = 1'b1;
                rf_waddr = dbg_addr;
                rf_wdata = dbg_wdata;
            end
        end
    end

    regfile_32x32 #(
        .NREG (NREG)
    ) u_regfile (
        .clock       (clock),
        .reset       (reset),
        .raddr_a_i   (dec_rs),
        .rdata_a_o   (rf_rdata_a),
        .raddr_b_i   (dec_rt),
        .rdata_b_o   (rf_rdata_b),
        .we_i        (rf_we),
        .waddr_i     (rf_waddr),
        .wdata_i     (rf_wdata),
        .clr_we_i    (clr_walk && !reset),
        .clr_addr_i  (REG_AW'(clr_cnt_q)),
        .dbg_addr_i  (dbg_addr),
        .dbg_rdata_o (dbg_rdata)
    );

    assign alu_valid    = e_valid_q;
    assign alu_opcode   = e_op_q;
    assign alu_function = e_funct_q;
    assign alu_in1      = e_a_q;
    assign alu_in2      = e_b_q;
    assign illegal      = illegal_q;
    assign retire_valid = retire_valid_q;
    assign retire_rd    = retire_rd_q;
    assign retire_data  = retire_data_q;

endmodule

// File: tb/tb_r_type_issue.sv
// tb/tb_r_type_issue.sv - scoreboard bench for r_type_issue with a behavioural ALU stand-in
module tb_r_type_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'h0;
    logic        alu_valid;
    logic [5:0]  alu_opcode, alu_function;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        illegal;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_wdata = 32'h0;
    logic [31:0] dbg_rdata;

    always #5 clock = ~clock;

    r_type_issue #(.NREG(32), .CLEAR_CYCLES(32)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_function(alu_function),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
        .illegal(illegal),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    always_comb begin
        case (alu_function)
            6'b100000: alu_result = alu_in1 + alu_in2;
            6'b100010: alu_result = alu_in1 - alu_in2;
            6'b100110: alu_result = alu_in1 * alu_in2;
            6'b100100: alu_result = alu_in1 & alu_in2;
            6'b100101: alu_result = alu_in1 | alu_in2;
            default:   alu_result = 32'h0;
        endcase
    end

    typedef struct {
        int          at;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
    } alu_exp_t;

    typedef struct {
        int          at;
        logic [4:0]  rd;
        logic [31:0] data;
    } ret_exp_t;

    alu_exp_t alu_q[$];
    ret_exp_t ret_q[$];
    int       ill_q[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    alu_exp_t ae;
    ret_exp_t re;
    int       ie;
    always @(negedge clock) begin
        if (alu_valid === 1'b1) begin
            if (alu_q.size() == 0) begin
                check("alu_unexpected", 32'd1, 32'd0);
            end else begin
                ae = alu_q.pop_front();
                check("alu_cycle", cyc, ae.at);
                check("alu_opcode", {26'd0, alu_opcode}, 32'd0);
                check("alu_function", {26'd0, alu_function}, {26'd0, ae.funct});
                check("alu_in1", alu_in1, ae.a);
                check("alu_in2", alu_in2, ae.b);
            end
        end
        if (retire_valid === 1'b1) begin
            if (ret_q.size() == 0) begin
                check("retire_unexpected", 32'd1, 32'd0);
            end else begin
                re = ret_q.pop_front();
                check("retire_cycle", cyc, re.at);
                check("retire_rd", {27'd0, retire_rd}, {27'd0, re.rd});
                check("retire_data", retire_data, re.data);
            end
        end
        if (illegal === 1'b1) begin
            if (ill_q.size() == 0) begin
                check("illegal_unexpected", 32'd1, 32'd0);
            end else begin
                ie = ill_q.pop_front();
                check("illegal_cycle", cyc, ie);
            end
        end
    end

    task automatic issue(input logic [31:0] w, input logic legal, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b, input logic do_ret,
                         input logic [4:0] rd, input logic [31:0] data);
        alu_exp_t x;
        ret_exp_t r;
        instr       = w;
        instr_valid = 1'b1;
        check("instr_ready", {31'd0, instr_ready}, 32'd1);
        if (legal) begin
            x.at = cyc + 1; x.funct = funct; x.a = a; x.b = b;
            alu_q.push_back(x);
            if (do_ret) begin
                r.at = cyc + 2; r.rd = rd; r.data = data;
                ret_q.push_back(r);
            end
        end else begin
            ill_q.push_back(cyc + 1);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic dbg_write(input logic [4:0] addr, input logic [31:0] data);
        dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
        @(negedge clock);
        dbg_we = 1'b0;
    endtask

    task automatic dbg_read(input string name, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        @(negedge clock);
        check(name, dbg_rdata, exp);
    endtask

    task automatic release_and_wait(input string name);
        int n;
        reset = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            n++;
            if (instr_ready === 1'b1) break;
        end
        check(name, n, 32'd32);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        check("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_alu_op_funct", {20'd0, alu_opcode, alu_function}, 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_retire_rd", {27'd0, retire_rd}, 32'd0);
        check("rst_retire_data", retire_data, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);

        release_and_wait("clear_walk_len");
        dbg_read("clear_r7", 5'd7, 32'd0);

        // add r3, r1, r2 with r1=5, r2=7
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        issue(32'h00221820, 1'b1, 6'b100000, 32'd5, 32'd7, 1'b1, 5'd3, 32'd12);
        idle(3);
        dbg_read("rf_r3_add", 5'd3, 32'd12);

        // and r3,r1,r2 then or r4,r3,r2 back-to-back (r3 must forward 0, not stale 12)
        dbg_write(5'd1, 32'd3);
        dbg_write(5'd2, 32'd4);
        issue(32'h00221824, 1'b1, 6'b100100, 32'd3, 32'd4, 1'b1, 5'd3, 32'd0);
        issue(32'h00622025, 1'b1, 6'b100101, 32'd0, 32'd4, 1'b1, 5'd4, 32'd4);
        idle(3);
        dbg_read("rf_r4_or", 5'd4, 32'd4);
        dbg_read("rf_r3_and", 5'd3, 32'd0);

        // sub r6,r1,r2 wraps; mul r7,r2,r2
        issue(32'h00223022, 1'b1, 6'b100010, 32'd3, 32'd4, 1'b1, 5'd6, 32'hFFFF_FFFF);
        issue(32'h00423826, 1'b1, 6'b100110, 32'd4, 32'd4, 1'b1, 5'd7, 32'd16);
        idle(3);
        dbg_read("rf_r6_sub", 5'd6, 32'hFFFF_FFFF);

        // illegal opcode 001000
        issue(32'h20010005, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(3);

        // add r0,r1,r2 then add r5,r0,r1: r0 never forwarded
        dbg_write(5'd1, 32'd1);
        dbg_write(5'd2, 32'd2);
        issue(32'h00220020, 1'b1, 6'b100000, 32'd1, 32'd2, 1'b1, 5'd0, 32'd3);
        issue(32'h00012820, 1'b1, 6'b100000, 32'd0, 32'd1, 1'b1, 5'd5, 32'd1);
        idle(3);
        dbg_read("rf_r0", 5'd0, 32'd0);
        dbg_read("rf_r5", 5'd5, 32'd1);

        // reset while add r9 is in E: no retire, r9 cleared
        dbg_write(5'd9, 32'h55);
        dbg_read("rf_r9_pre", 5'd9, 32'h55);
        issue(32'h00224820, 1'b1, 6'b100000, 32'd1, 32'd2, 1'b0, 5'd9, 32'd3);
        instr_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        release_and_wait("clear_walk_len2");
        dbg_read("rf_r9_cleared", 5'd9, 32'd0);
        idle(2);

        check("alu_q_drained", alu_q.size(), 32'd0);
        check("ret_q_drained", ret_q.size(), 32'd0);
        check("ill_q_drained", ill_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/r_type_issue.md
# r_type_issue

Issue and writeback stage that drives the ALU in the MIPS CPU. It accepts 32-bit instruction words over a valid/ready handshake and decodes R-type fields. It reads operands from an internal 32x32 register file, with forwarding from the instruction in flight, and presents opcode, function code and operands to the ALU. It captures `answerOut` one cycle later, writes it to `rd`, and reports the retirement.

## Interface
- `NREG`, 32: architectural registers; fixed at 32, since the 5-bit fields depend on it.
- `CLEAR_CYCLES`, `NREG`: length of the post-reset register-file clear walk.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  `instr` holds a word to issue.
- `instr_ready`  out  1  the unit accepts `instr` this cycle.
- `instr`  in  32  MIPS instruction word.
- `alu_valid`  out  1  the ALU drive signals carry a live instruction this cycle.
- `alu_opcode`  out  6  connects to the ALU `opcode` input.
- `alu_function`  out  6  connects to the ALU `functionCode` input.
- `alu_in1` / `alu_in2`  out  32  connect to the ALU `nIn1` / `nIn2` inputs.
- `alu_result`  in  32  connects to the ALU `answerOut` output (combinational).
- `retire_valid`  out  1  one-cycle pulse per retired instruction.
- `retire_rd`  out  5  destination register of the retired instruction.
- `retire_data`  out  32  value written to `retire_rd`.
- `illegal`  out  1  one-cycle pulse when an accepted word is rejected.
- `dbg_we`  in  1  backdoor register write.
- `dbg_addr`  in  5  backdoor register address.
- `dbg_wdata`  in  32  backdoor register write data.
- `dbg_rdata`  out  32  registered read of `dbg_addr`.

## Operation
- States: CLEAR and RUN.
  - `reset` forces CLEAR and sets the clear counter to 0.
  - In CLEAR, each cycle with `reset` low zeroes register[counter] and increments the counter.
  - After `CLEAR_CYCLES` such cycles the state moves to RUN.
- `instr_ready` = (state == RUN) && !`reset`.
- An instruction is accepted on an edge where `instr_valid` && `instr_ready`. At acceptance, decode:
  - `op` = [31:26], `rs` = [25:21], `rt` = [20:16], `rd` = [15:11], `funct` = [5:0].
  - `shamt` is ignored.
- A word is legal when `op` == 000000 and `funct` is one of: 100000 add, 100010 sub, 100110 mul, 100100 and, 100101 or.
- Legal word:
  - E-stage registers load `op`, `funct`, operand A (from `rs`), operand B (from `rt`), `rd`; the E-stage valid bit is set.
- Illegal word:
  - The word is consumed and `illegal` pulses on the next cycle.
  - E-stage valid clears and no retire follows.
- Operand read, applied to `rs` and `rt` independently:
  - Index 0 reads 0.
  - If the index equals E.`rd`, E is valid and E.`rd` != 0, the operand is forwarded from `alu_result`.
  - Otherwise the operand comes from the register file.
- The ALU drive signals (`alu_valid`, `alu_opcode`, `alu_function`, `alu_in1`, `alu_in2`) are the E-stage registers.
  - With no accept, `alu_valid` drops and the other drive signals hold their last values.
- Retire, on the edge ending a valid E cycle:
  - `alu_result` is written to register[E.`rd`]; writes to index 0 are discarded.
  - `retire_valid`, `retire_rd` and `retire_data` are registered.
  - The retire pulse still fires when `rd` is 0, with `retire_data` = `alu_result`.
- Arithmetic is entirely inside the ALU; this unit never alters operands or results. All widths are 32 bits; overflow is not detected.
- Debug port:
  - A `dbg_we` write takes effect only in RUN.
  - When a debug write and a retire target the same index on the same edge, the retire wins.
  - `dbg_rdata` is the register value one edge after the address is presented (value before any same-edge write).

## Timing
- Reset values:
  - `instr_ready`, `alu_valid`, `retire_valid`, `illegal`: 0.
  - `alu_opcode`, `alu_function`: 0. `alu_in1`, `alu_in2`: 0.
  - `retire_rd`: 0. `retire_data`: 0. `dbg_rdata`: 0.
- After `reset` falls, `instr_ready` rises after exactly `CLEAR_CYCLES` clocks.
- Latency:
  - Accept at edge N.
  - `alu_valid` high during cycle N+1.
  - Writeback at edge N+1; `retire_valid` high in cycle N+2.
- Throughput: one instruction per clock with no stalls; back-to-back dependencies are covered by forwarding alone.
- Reset mid-operation: the E-stage instruction is discarded with no retire, and CLEAR restarts from index 0.

## Structure
- Package `r_type_pkg`:
  - Opcode constant `OP_RTYPE`.
  - `FUNCT_ADD`, `FUNCT_SUB`, `FUNCT_MUL`, `FUNCT_AND`, `FUNCT_OR`.
  - Field bit positions.
  - State enum {CLEAR, RUN}.
- Sub-module `regfile_32x32`:
  - Two combinational read ports, one debug read port (registered).
  - One write port plus the clear-walk write.
- Decode, forward muxes and the FSM live in the top module.

## Test plan
- Clear walk: `reset` for 2 cycles, then release -> `instr_ready` = 0 for 32 cycles then 1; `dbg_rdata` reads 0 for register 7.
- Simple add: debug-write r1 = 5, r2 = 7, then issue 0x00221820 (add r3, r1, r2).
  - ALU side: `alu_in1` = 5, `alu_in2` = 7, `alu_function` = 100000.
  - Retire: `retire_rd` = 3, `retire_data` = 12 two cycles after acceptance.
- Forwarding: r1 = 3, r2 = 4. Issue back-to-back 0x00221824 (and r3, r1, r2), then 0x00622025 (or r4, r3, r2).
  - Second issue: `alu_in1` equals the first `alu_result` (0).
  - Retire: r4 = 4 with no bubble.
- Illegal word: issue 0x20010005 (`op` 001000) -> `illegal` pulses once; no `alu_valid`, no retire.
- Register zero: issue 0x00220020 (add r0, r1, r2) with r1 = 1, r2 = 2.
  - Retire: `retire_rd` = 0, `retire_data` = 3.
  - A later read of r0 operand still gives 0.
- Reset mid-flight: assert `reset` in the cycle `alu_valid` = 1 -> no `retire_valid`; target register reads 0 after the new clear.
